// File: rtl/pixel_filter_pkg.sv
// Shared types and luma constants for the pixel_filter video block.
// PIXEL_FILTER_THRESH_EN enables THRESH; otherwise mode 3 decodes to PASS.
package pixel_filter_pkg;

  typedef enum logic [1:0] {
    PASS   = 2'd0,
    GREY   = 2'd1,
    INVERT = 2'd2,
    THRESH = 2'd3
  } mode_e;

  // 19 + 38 + 7 = 64, so white stays white after the shift
  localparam int unsigned LUMA_CR    = 19;
  localparam int unsigned LUMA_CG    = 38;
  localparam int unsigned LUMA_CB    = 7;
  localparam int unsigned LUMA_SHIFT = 6;

  function automatic mode_e mode_decode(input logic [1:0] m);
    mode_e r;
    case (m)
      2'd1:    r = GREY;
      2'd2:    r = INVERT;
`ifdef PIXEL_FILTER_THRESH_EN
      2'd3:    r = THRESH;
`endif
      default: r = PASS;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pixel_filter_rgb_to_luma.sv
// Combinational weighted RGB sum feeding the stage-1 luma register.
// Output width CH_W+7 cannot overflow for a full-scale pixel.
module rgb_to_luma
  import pixel_filter_pkg::*;
#(
  parameter int CH_W = 8
) (
  input  logic [CH_W-1:0] i_r,
  input  logic [CH_W-1:0] i_g,
  input  logic [CH_W-1:0] i_b,
  output logic [CH_W+6:0] o_sum
);

  localparam int SW = CH_W + 7;

  assign o_sum = SW'(LUMA_CR) * SW'(i_r)
               + SW'(LUMA_CG) * SW'(i_g)
               + SW'(LUMA_CB) * SW'(i_b);

endmodule

// File: rtl/pixel_filter.sv
// Two-stage AXI4-Stream pixel filter: PASS, GREY, INVERT, THRESH.
// THRESH and its comparator exist only with PIXEL_FILTER_THRESH_EN.
module pixel_filter
  import pixel_filter_pkg::*;
#(
  parameter int CH_W        = 8,
  parameter int THR_DEFAULT = 128
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [3*CH_W-1:0] s_axis_video_tdata,
  input  logic              s_axis_video_tvalid,
  input  logic              s_axis_video_tlast,
  input  logic              s_axis_video_tuser,
  output logic              s_axis_video_tready,
  output logic [3*CH_W-1:0] m_axis_video_tdata,
  output logic              m_axis_video_tvalid,
  output logic              m_axis_video_tlast,
  output logic              m_axis_video_tuser,
  input  logic              m_axis_video_tready,
  input  logic [1:0]        mode_i,
  input  logic [CH_W-1:0]   thresh_i,
  output logic [1:0]        mode_active_o
);

  localparam int SW = CH_W + 7;
  localparam int PW = 3 * CH_W;

  logic            w_en;
  logic            w_accept;
  logic [CH_W-1:0] w_r;
  logic [CH_W-1:0] w_g;
  logic [CH_W-1:0] w_b;
  logic [SW-1:0]   w_sum;
  mode_e           w_mode_in;
  logic [CH_W-1:0] w_luma;
  logic [PW-1:0]   w_out;
  logic            w_unused;

  logic          r_s1_valid;
  logic          r_s1_last;
  logic          r_s1_user;
  logic [PW-1:0] r_s1_pix;
  logic [SW-1:0] r_s1_sum;
  mode_e         r_s1_mode;

  logic          r_s2_valid;
  logic          r_s2_last;
  logic          r_s2_user;
  logic [PW-1:0] r_s2_pix;

  mode_e r_mode_active;

  assign w_en = !r_s2_valid || m_axis_video_tready;
  assign s_axis_video_tready = w_en && !areset;
  assign w_accept = s_axis_video_tvalid && s_axis_video_tready;
  assign {w_r, w_b, w_g} = s_axis_video_tdata;

  // a new mode takes effect on its own start-of-frame beat
  assign w_mode_in = (w_accept && s_axis_video_tuser)
                   ? mode_decode(mode_i) : r_mode_active;

  rgb_to_luma #(
    .CH_W (CH_W)
  ) u_luma (
    .i_r   (w_r),
    .i_g   (w_g),
    .i_b   (w_b),
    .o_sum (w_sum)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_s1_valid    <= 1'b0;
      r_s1_last     <= 1'b0;
      r_s1_user     <= 1'b0;
      r_s1_pix      <= '0;
      r_s1_sum      <= '0;
      r_s1_mode     <= PASS;
      r_mode_active <= PASS;
    end else if (w_en) begin
      r_s1_valid    <= w_accept;
      r_s1_last     <= s_axis_video_tlast;
      r_s1_user     <= s_axis_video_tuser;
      r_s1_pix      <= s_axis_video_tdata;
      r_s1_sum      <= w_sum;
      r_s1_mode     <= w_mode_in;
      r_mode_active <= w_mode_in;
    end
  end

  assign w_luma = r_s1_sum[LUMA_SHIFT +: CH_W];

  always_comb begin
    w_out = r_s1_pix;
    case (r_s1_mode)
      GREY:    w_out = {3{w_luma}};
      INVERT:  w_out = ~r_s1_pix;
`ifdef PIXEL_FILTER_THRESH_EN
      THRESH:  w_out = (w_luma >= thresh_i) ? '1 : '0;
`endif
      default: w_out = r_s1_pix;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_user  <= 1'b0;
      r_s2_pix   <= '0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_user  <= r_s1_user;
      r_s2_pix   <= w_out;
    end
  end

  assign m_axis_video_tdata  = r_s2_pix;
  assign m_axis_video_tvalid = r_s2_valid;
  assign m_axis_video_tlast  = r_s2_last;
  assign m_axis_video_tuser  = r_s2_user;
  assign mode_active_o       = r_mode_active;

  assign w_unused = ^{thresh_i, 1'(THR_DEFAULT),
                      r_s1_sum[SW-1], r_s1_sum[LUMA_SHIFT-1:0]};

endmodule

// File: tb/tb_pixel_filter.sv
// Directed bench for pixel_filter (CH_W=8).
// Follows PIXEL_FILTER_THRESH_EN for THRESH expectations.
`timescale 1ns/1ps
module tb_pixel_filter;

  logic        aclk = 1'b0;
  logic        areset;
  logic [23:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tuser;
  logic        s_tready;
  logic [23:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tuser;
  logic        m_tready;
  logic [1:0]  mode_i;
  logic [1:0]  mode_act;
  logic [7:0]  thresh_i;

  int total = 0;
  int bad   = 0;
  logic [25:0] q[$];

  always #5 aclk = ~aclk;

  pixel_filter #(
    .CH_W        (8),
    .THR_DEFAULT (128)
  ) dut (
    .aclk                (aclk),
    .areset              (areset),
    .s_axis_video_tdata  (s_tdata),
    .s_axis_video_tvalid (s_tvalid),
    .s_axis_video_tlast  (s_tlast),
    .s_axis_video_tuser  (s_tuser),
    .s_axis_video_tready (s_tready),
    .m_axis_video_tdata  (m_tdata),
    .m_axis_video_tvalid (m_tvalid),
    .m_axis_video_tlast  (m_tlast),
    .m_axis_video_tuser  (m_tuser),
    .m_axis_video_tready (m_tready),
    .mode_i              (mode_i),
    .thresh_i            (thresh_i),
    .mode_active_o       (mode_act)
  );

  always @(posedge aclk)
    if (m_tvalid && m_tready)
      q.push_back({m_tuser, m_tlast, m_tdata});

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic push_beat(input logic [23:0] d, input logic l,
                           input logic u, output int n);
    n = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tuser  = u;
    s_tvalid = 1'b1;
    do begin
      @(posedge aclk);
      n++;
    end while (!s_tready && n < 50);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    if (n >= 50) begin
      total++;
      bad++;
      $error("FAIL accept_timeout observed=%0d expected=<50", n);
    end
  endtask

  task automatic one(input logic [23:0] d, input logic u,
                     input logic [1:0] m, output logic [23:0] o);
    int n;
    mode_i = m;
    push_beat(d, 1'b1, u, n);
    tick(1);
    o = m_tdata;
    tick(1);
  endtask

  function automatic logic [23:0] pix(input int i);
    return {8'(16 * i + 1), 8'(200 - i), 8'(7 * i)};
  endfunction

  initial begin
    logic [23:0] o;
    int n;
    int cyc;
    logic [23:0] exp_d;

    areset   = 1'b1;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    m_tready = 1'b1;
    mode_i   = 2'd0;
    thresh_i = 8'd128;

    // reset state
    tick(2);
    chk("rst_mvalid", 32'(m_tvalid), 0);
    chk("rst_tready", 32'(s_tready), 0);
    chk("rst_tdata", 32'(m_tdata), 0);
    chk("rst_side", 32'({m_tuser, m_tlast}), 0);
    chk("rst_mode", 32'(mode_act), 0);
    areset = 1'b0;
    #1;
    chk("rel_tready", 32'(s_tready), 1);

    // GREY R=100 G=50 B=200, latency 2
    mode_i   = 2'd1;
    s_tdata  = 24'h64C832;
    s_tuser  = 1'b1;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    tick(1);
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    chk("lat1_valid", 32'(m_tvalid), 0);
    tick(1);
    chk("lat2_valid", 32'(m_tvalid), 1);
    chk("grey_data", 32'(m_tdata), 32'h515151);
    chk("grey_side", 32'({m_tuser, m_tlast}), 32'h3);
    chk("grey_mode", 32'(mode_act), 1);
    tick(1);

    one(24'h1020F0, 1'b1, 2'd2, o);
    chk("invert", 32'(o), 32'hEFDF0F);
    chk("invert_mode", 32'(mode_act), 2);
    one(24'h1020F0, 1'b1, 2'd0, o);
    chk("pass", 32'(o), 32'h1020F0);
    one(24'hFFFFFF, 1'b1, 2'd1, o);
    chk("grey_white", 32'(o), 32'hFFFFFF);
    one(24'h1020F0, 1'b0, 2'd2, o);
    chk("midframe_ignored", 32'(o), 32'h969696);
    one(24'h000000, 1'b1, 2'd2, o);
    chk("invert_black", 32'(o), 32'hFFFFFF);

    // THRESH at 128: luma 127 then 128
    one(24'h7F7F7F, 1'b1, 2'd3, o);
`ifdef PIXEL_FILTER_THRESH_EN
    chk("thr_127", 32'(o), 32'h000000);
    chk("thr_mode", 32'(mode_act), 3);
`else
    chk("thr_127_pass", 32'(o), 32'h7F7F7F);
    chk("thr_mode_pass", 32'(mode_act), 0);
`endif
    one(24'h808080, 1'b1, 2'd3, o);
`ifdef PIXEL_FILTER_THRESH_EN
    chk("thr_128", 32'(o), 32'hFFFFFF);
`else
    chk("thr_128_pass", 32'(o), 32'h808080);
`endif

    // GREY frame with mode_i switched to INVERT at pixel 7
    tick(2);
    q.delete();
    mode_i = 2'd1;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 7) mode_i = 2'd2;
      push_beat((i % 2 == 0) ? 24'h64C832 : 24'h1020F0,
                i == 9, i == 0, n);
      cyc += n;
    end
    chk("frame_a_cycles", 32'(cyc), 10);
    tick(3);
    chk("frame_a_count", 32'(q.size()), 10);
    chk("frame_a_mode", 32'(mode_act), 1);
    for (int i = 0; i < 10 && i < q.size(); i++) begin
      exp_d = (i % 2 == 0) ? 24'h515151 : 24'h969696;
      chk("frame_a_beat", 32'(q[i]),
          32'({i == 0, i == 9, exp_d}));
    end

    q.delete();
    push_beat(24'h64C832, 1'b0, 1'b1, n);
    chk("frame_b_mode", 32'(mode_act), 2);
    push_beat(24'h1020F0, 1'b1, 1'b0, n);
    tick(3);
    chk("frame_b_count", 32'(q.size()), 2);
    if (q.size() == 2) begin
      chk("frame_b_0", 32'(q[0]), 32'h29B37CD);
      chk("frame_b_1", 32'(q[1]), 32'h1EFDF0F);
    end

    // 16-pixel PASS line with a 5-cycle downstream stall
    q.delete();
    mode_i = 2'd0;
    fork
      begin
        int nn;
        for (int i = 0; i < 16; i++)
          push_beat(pix(i), i == 15, i == 0, nn);
      end
      begin
        tick(6);
        m_tready = 1'b0;
        chk("stall_valid", 32'(m_tvalid), 1);
        for (int k = 0; k < 5; k++) begin
          tick(1);
          chk("stall_data", 32'(m_tdata), 32'(pix(4)));
          chk("stall_rdy", 32'(s_tready), 0);
        end
        m_tready = 1'b1;
      end
    join
    tick(4);
    chk("line_count", 32'(q.size()), 16);
    for (int i = 0; i < 16 && i < q.size(); i++)
      chk("line_beat", 32'(q[i]), 32'({i == 0, i == 15, pix(i)}));

    // reset with two pixels in flight
    mode_i = 2'd1;
    push_beat(24'h64C832, 1'b0, 1'b1, n);
    push_beat(24'h64C832, 1'b0, 1'b0, n);
    areset = 1'b1;
    #1;
    chk("rst2_tready_lo", 32'(s_tready), 0);
    tick(1);
    chk("rst2_valid", 32'(m_tvalid), 0);
    chk("rst2_data", 32'(m_tdata), 0);
    chk("rst2_mode", 32'(mode_act), 0);
    areset = 1'b0;
    #1;
    chk("rst2_tready_hi", 32'(s_tready), 1);
    q.delete();
    tick(3);
    chk("rst2_no_partial", 32'(q.size()), 0);
    mode_i = 2'd2;
    push_beat(24'h1020F0, 1'b0, 1'b1, n);
    push_beat(24'h64C832, 1'b1, 1'b0, n);
    tick(3);
    chk("post_rst_count", 32'(q.size()), 2);
    if (q.size() == 2) begin
      chk("post_rst_0", 32'(q[0]), 32'h2EFDF0F);
      chk("post_rst_1", 32'(q[1]), 32'h19B37CD);
    end
    chk("post_rst_mode", 32'(mode_act), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_filter.md
PIXEL_FILTER -- requirements
Module: pixel_filter

Interface
REQ-001 Parameter CH_W, default 8: bits per colour channel, legal range 8..12.
REQ-002 Parameter THR_DEFAULT, default 128: threshold value used when the threshold input is unconnected in the testbench wrapper.
REQ-003 aclk  input  1  sole clock; all logic rising-edge.
REQ-004 areset  input  1  reset, synchronous and active-high.
REQ-005 s_axis_video_tdata  input  3*CH_W  pixel, channel order {R,B,G}, MSB to LSB.
REQ-006 s_axis_video_tvalid / tlast / tuser  input  1 each  AXI4-Stream valid, end-of-line, start-of-frame.
REQ-007 s_axis_video_tready  output  1  upstream ready.
REQ-008 m_axis_video_tdata  output  3*CH_W  processed pixel, order {R,B,G}.
REQ-009 m_axis_video_tvalid / tlast / tuser  output  1 each  delayed copies of the input sideband.
REQ-010 m_axis_video_tready  input  1  downstream ready.
REQ-011 mode_i  input  2  requested mode: 0 PASS, 1 GREY, 2 INVERT, 3 THRESH.
REQ-012 thresh_i  input  CH_W  luma threshold for THRESH.
REQ-013 mode_active_o  output  2  mode currently applied.

Function
REQ-014 Two-stage pipeline, latency exactly 2 accepted-to-presented cycles, full throughput of 1 pixel/cycle.
REQ-015 Pipeline enable en = !m_axis_video_tvalid || m_axis_video_tready; both stages advance only when en=1.
REQ-016 s_axis_video_tready = en, except 0 during reset.
REQ-017 Input beat accepted only when tvalid && tready; output beat consumed only when tvalid && tready.
REQ-018 While m_axis_video_tvalid=1 and m_axis_video_tready=0: tdata, tlast and tuser hold stable, and nothing is accepted.
REQ-019 Stage 1 registers luma sum 19*R + 38*G + 7*B at width CH_W+7 with no overflow.
REQ-020 Stage 2 registers luma = sum >> 6 (truncate); white in gives white out (e.g. 255 when CH_W=8).
REQ-021 PASS: output equals input unchanged.
REQ-022 GREY: all three channels equal luma.
REQ-023 INVERT: each channel becomes (2^CH_W - 1) - channel.
REQ-024 THRESH: all channels become 2^CH_W - 1 if luma >= thresh_i, otherwise 0.
REQ-025 mode_i is sampled only on an accepted beat with tuser=1; that beat and the rest of the frame use the new mode.
REQ-026 mode changes in mid-frame are ignored until the next tuser beat.
REQ-027 tlast and tuser travel with their pixel through both stages; they are never regenerated.
REQ-028 An accept and a consume in the same cycle are both honoured with no bubble.

Reset
REQ-029 When areset=1 at a clock edge: both stage valids clear to 0 and m_axis_video_tvalid, tlast and tuser go to 0.
REQ-030 On reset, m_axis_video_tdata goes to 0 and mode_active_o goes to PASS.
REQ-031 s_axis_video_tready is 0 while areset=1 and is 1 on the first cycle after release.
REQ-032 Reset mid-frame discards in-flight pixels; no partial beat is presented afterwards.

Configuration
REQ-033 Macro PIXEL_FILTER_THRESH_EN gates THRESH mode.
REQ-034 With PIXEL_FILTER_THRESH_EN defined: THRESH operates as in REQ-024.
REQ-035 Without PIXEL_FILTER_THRESH_EN: thresh_i is unused, the comparator is not built, and mode 3 is latched as PASS (mode_active_o=0).

Structure
REQ-036 Package pixel_filter_pkg holds the mode_e enum (PASS, GREY, INVERT, THRESH) and the luma coefficient constants 19, 38, 7 and shift 6.
REQ-037 Sub-module rgb_to_luma (parameter CH_W, combinational weighted sum) is instantiated once in stage 1.

Verification
REQ-038 GREY, CH_W=8, pixel R=100 G=50 B=200 -> output {81,81,81} two cycles after accept.
REQ-039 INVERT, pixel {R=0x10,B=0x20,G=0xF0} -> {0xEF,0xDF,0x0F}; PASS, same pixel -> unchanged.
REQ-040 Downstream tready low for 5 cycles during a 16-pixel line -> no loss, no duplication, output data stable while stalled, tlast on pixel 16 only.
REQ-041 mode_i changed GREY->INVERT at pixel 7 of a frame -> GREY holds to frame end; INVERT from the next tuser beat; mode_active_o tracks.
REQ-042 THRESH with thresh_i=128: luma 127 -> 0x000000, luma 128 -> 0xFFFFFF; with macro undefined -> passthrough.
REQ-043 areset pulsed for 1 cycle with 2 pixels in flight -> tvalid=0 next cycle, tready=1 on the cycle after, and the next frame is processed correctly.
